mix_route_seq: RTL and testbench

- Sequencer for the parametrised successor of the 5-input / 5-output pump–mixer–pump fluidic core.
- The fluidic core has input junction trees, a load pump, a mixing chamber, an unload pump and output junction trees.
- The block takes one transfer command at a time and runs LOAD → MIX → UNLOAD.
- It drives input/output valve selects, 3-chamber peristaltic pump patterns and a mixer pattern from a programmable step timer.

---
 rtl/mix_route_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_mix_route_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_route_seq.sv
// Sequencer for the pump-mixer-pump fluidic core: runs LOAD -> MIX -> UNLOAD per command,
// driving valve selects and 3-chamber peristaltic patterns from a programmable step timer.
module mix_route_seq #(
    parameter int unsigned N_IN  = 5,
    parameter int unsigned N_OUT = 5,
    parameter int unsigned CNT_W = 12,
    parameter int unsigned DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [$clog2(N_IN)-1:0]  cmd_in_sel,
    input  logic [$clog2(N_OUT)-1:0] cmd_out_sel,
    input  logic [CNT_W-1:0]         cmd_load,
    input  logic [CNT_W-1:0]         cmd_mix,
    input  logic [CNT_W-1:0]         cmd_unload,
    input  logic [DIV_W-1:0]         cmd_div,
    input  logic                     abort,
    output logic [N_IN-1:0]          in_valve,
    output logic [N_OUT-1:0]         out_valve,
    output logic [2:0]               pump_load,
    output logic [2:0]               pump_unload,
    output logic [2:0]               mix_drive,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned IN_W  = $clog2(N_IN);
    localparam int unsigned OUT_W = $clog2(N_OUT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_MIX    = 3'd2;
    localparam logic [2:0] S_UNLOAD = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [2:0] LAST_IDX = 3'd5;

    // Peristaltic pattern, bit2 = chamber A; one stroke is six steps.
    function automatic logic [2:0] pat(input logic [2:0] idx);
        case (idx)
            3'd0:    pat = 3'b100;
            3'd1:    pat = 3'b110;
            3'd2:    pat = 3'b010;
            3'd3:    pat = 3'b011;
            3'd4:    pat = 3'b001;
            3'd5:    pat = 3'b101;
            default: pat = 3'b000;
        endcase
    endfunction

    // First stage with a non-zero count, so zero-count stages cost no cycles.
    function automatic logic [2:0] next_stage(input logic ld_nz, input logic mx_nz,
                                              input logic ul_nz);
        if (ld_nz)      next_stage = S_LOAD;
        else if (mx_nz) next_stage = S_MIX;
        else if (ul_nz) next_stage = S_UNLOAD;
        else            next_stage = S_DONE;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] timer_q, timer_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  in_sel_q, in_sel_d;
    logic [OUT_W-1:0] out_sel_q, out_sel_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] mix_q, mix_d;
    logic [CNT_W-1:0] unload_q, unload_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic [N_IN-1:0]  in_valve_q, in_valve_d;
    logic [N_OUT-1:0] out_valve_q, out_valve_d;
    logic [2:0]       pump_load_q, pump_load_d;
    logic [2:0]       pump_unload_q, pump_unload_d;
    logic [2:0]       mix_drive_q, mix_drive_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             step;
    logic [CNT_W-1:0] target;
    logic [2:0]       stage_after;

    assign cmd_ready = (state_q == S_IDLE) && !abort;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        in_sel_d  = in_sel_q;
        out_sel_d = out_sel_q;
        load_d    = load_q;
        mix_d     = mix_q;
        unload_d  = unload_q;
        div_d     = div_q;
        err_d     = 1'b0;

        step = (timer_q == div_q);

        case (state_q)
            S_LOAD:  target = load_q;
            S_MIX:   target = mix_q;
            default: target = unload_q;
        endcase

        case (state_q)
            S_LOAD:  stage_after = next_stage(1'b0, mix_q != '0, unload_q != '0);
            S_MIX:   stage_after = next_stage(1'b0, 1'b0, unload_q != '0);
            default: stage_after = S_DONE;
        endcase

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if ((32'(cmd_in_sel) >= N_IN) || (32'(cmd_out_sel) >= N_OUT)) begin
                        err_d = 1'b1;
                    end else begin
                        in_sel_d  = cmd_in_sel;
                        out_sel_d = cmd_out_sel;
                        load_d    = cmd_load;
                        mix_d     = cmd_mix;
                        unload_d  = cmd_unload;
                        div_d     = cmd_div;
                        state_d   = next_stage(cmd_load != '0, cmd_mix != '0, cmd_unload != '0);
                        timer_d   = '0;
                        idx_d     = '0;
                        cnt_d     = '0;
                    end
                end
            end
            S_LOAD, S_MIX, S_UNLOAD: begin
                if (step) begin
                    timer_d = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (cnt_q + CNT_W'(1) == target) begin
                            cnt_d   = '0;
                            state_d = stage_after;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + DIV_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            timer_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
        end

        // Outputs are a function of the upcoming state so they land registered on its first cycle.
        in_valve_d    = '0;
        out_valve_d   = '0;
        pump_load_d   = '0;
        pump_unload_d = '0;
        mix_drive_d   = '0;
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
        case (state_d)
            S_LOAD: begin
                in_valve_d  = N_IN'(1) << in_sel_d;
                pump_load_d = pat(idx_d);
            end
            S_MIX: mix_drive_d = pat(idx_d);
            S_UNLOAD: begin
                out_valve_d   = N_OUT'(1) << out_sel_d;
                pump_unload_d = pat(idx_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            in_sel_q      <= '0;
            out_sel_q     <= '0;
            load_q        <= '0;
            mix_q         <= '0;
            unload_q      <= '0;
            div_q         <= '0;
            in_valve_q    <= '0;
            out_valve_q   <= '0;
            pump_load_q   <= '0;
            pump_unload_q <= '0;
            mix_drive_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            in_sel_q      <= in_sel_d;
            out_sel_q     <= out_sel_d;
            load_q        <= load_d;
            mix_q         <= mix_d;
            unload_q      <= unload_d;
            div_q         <= div_d;
            in_valve_q    <= in_valve_d;
            out_valve_q   <= out_valve_d;
            pump_load_q   <= pump_load_d;
            pump_unload_q <= pump_unload_d;
            mix_drive_q   <= mix_drive_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign in_valve    = in_valve_q;
    assign out_valve   = out_valve_q;
    assign pump_load   = pump_load_q;
    assign pump_unload = pump_unload_q;
    assign mix_drive   = mix_drive_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mix_route_seq.sv
// Bench for mix_route_seq: per-cycle expected output snapshots are queued from a
// stage-length model when a command is driven and popped against the DUT each cycle.
module tb_mix_route_seq;

    localparam int unsigned N_IN  = 5;
    localparam int unsigned N_OUT = 5;
    localparam int unsigned CNT_W = 12;
    localparam int unsigned DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_in_sel;
    logic [2:0]       cmd_out_sel;
    logic [CNT_W-1:0] cmd_load;
    logic [CNT_W-1:0] cmd_mix;
    logic [CNT_W-1:0] cmd_unload;
    logic [DIV_W-1:0] cmd_div;
    logic             abort;
    logic [N_IN-1:0]  in_valve;
    logic [N_OUT-1:0] out_valve;
    logic [2:0]       pump_load;
    logic [2:0]       pump_unload;
    logic [2:0]       mix_drive;
    logic             busy;
    logic             done;
    logic             err;

    mix_route_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_in_sel(cmd_in_sel), .cmd_out_sel(cmd_out_sel), .cmd_load(cmd_load),
        .cmd_mix(cmd_mix), .cmd_unload(cmd_unload), .cmd_div(cmd_div), .abort(abort),
        .in_valve(in_valve), .out_valve(out_valve), .pump_load(pump_load),
        .pump_unload(pump_unload), .mix_drive(mix_drive), .busy(busy), .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             err;
        logic             ready;
        logic [N_IN-1:0]  in_v;
        logic [N_OUT-1:0] out_v;
        logic [2:0]       pl;
        logic [2:0]       pu;
        logic [2:0]       md;
    } obs_t;

    obs_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic logic [2:0] tpat(input int i);
        case (i)
            0:       tpat = 3'b100;
            1:       tpat = 3'b110;
            2:       tpat = 3'b010;
            3:       tpat = 3'b011;
            4:       tpat = 3'b001;
            default: tpat = 3'b101;
        endcase
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.busy  = busy;
        o.done  = done;
        o.err   = err;
        o.ready = cmd_ready;
        o.in_v  = in_valve;
        o.out_v = out_valve;
        o.pl    = pump_load;
        o.pu    = pump_unload;
        o.md    = mix_drive;
        return o;
    endfunction

    task automatic push_idle(input logic ready);
        obs_t e;
        e       = '0;
        e.ready = ready;
        exp_q.push_back(e);
    endtask

    // Expected trace: each stage lasts count*6*(div+1) cycles, then DONE, then idle cycles.
    task automatic push_seq(input int in_sel, input int out_sel, input int ld, input int mx,
                            input int ul, input int dv, input int n_idle);
        int   cnt [3];
        obs_t e;
        logic [2:0] p;
        cnt[0] = ld;
        cnt[1] = mx;
        cnt[2] = ul;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < cnt[s] * 6 * (dv + 1); k++) begin
                e      = '0;
                e.busy = 1'b1;
                p      = tpat((k / (dv + 1)) % 6);
                if (s == 0) begin
                    e.in_v = N_IN'(1) << in_sel;
                    e.pl   = p;
                end else if (s == 1) begin
                    e.md = p;
                end else begin
                    e.out_v = N_OUT'(1) << out_sel;
                    e.pu    = p;
                end
                exp_q.push_back(e);
            end
        end
        e      = '0;
        e.busy = 1'b1;
        e.done = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < n_idle; i++) push_idle(1'b1);
    endtask

    task automatic check_one(input string tag);
        obs_t e;
        obs_t o;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_total = n_total + 1;
            $error("FAIL %s: observed empty-queue expected queued entry", tag);
        end else begin
            e = exp_q.pop_front();
            o = sample();
            n_total = n_total + 1;
            assert (o === e) n_pass = n_pass + 1;
            else $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic check_n(input int n, input string tag);
        for (int i = 0; i < n; i++) check_one(tag);
    endtask

    task automatic check_all(input string tag);
        while (exp_q.size() != 0) check_one(tag);
    endtask

    task automatic send(input int in_sel, input int out_sel, input int ld, input int mx,
                        input int ul, input int dv, input bit keep);
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_in_sel  = 3'(in_sel);
        cmd_out_sel = 3'(out_sel);
        cmd_load    = CNT_W'(ld);
        cmd_mix     = CNT_W'(mx);
        cmd_unload  = CNT_W'(ul);
        cmd_div     = DIV_W'(dv);
        n_total = n_total + 1;
        assert (cmd_ready === 1'b1) n_pass = n_pass + 1;
        else $error("FAIL send_ready: observed %b expected 1", cmd_ready);
        @(posedge clk);
        if (!keep) begin
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        obs_t e;
        rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
        cmd_in_sel = '0; cmd_out_sel = '0; cmd_load = '0; cmd_mix = '0;
        cmd_unload = '0; cmd_div = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        push_idle(1'b1);
        check_one("reset");

        // Full sequence, one step per clock
        send(2, 4, 2, 1, 1, 0, 0);
        push_seq(2, 4, 2, 1, 1, 0, 1);
        check_all("full_div0");

        // Slow divider, MIX/UNLOAD skipped
        send(0, 0, 1, 0, 0, 3, 0);
        push_seq(0, 0, 1, 0, 0, 3, 1);
        check_all("div3_load_only");

        // Out-of-range selects are rejected
        send(5, 0, 1, 1, 1, 0, 0);
        e = '0; e.err = 1'b1; e.ready = 1'b1;
        exp_q.push_back(e);
        push_idle(1'b1);
        check_all("reject_in5");
        send(1, 7, 1, 1, 1, 0, 0);
        exp_q.push_back(e);
        push_idle(1'b1);
        check_all("reject_out7");

        // Abort on the 3rd MIX cycle
        send(1, 0, 1, 2, 1, 0, 0);
        push_seq(1, 0, 1, 2, 1, 0, 1);
        check_n(9, "abort_pre");
        abort = 1'b1;
        exp_q.delete();
        push_idle(1'b0);
        check_one("abort_idle");
        abort = 1'b0;
        push_idle(1'b1);
        check_one("abort_release");
        send(3, 2, 1, 0, 1, 1, 0);
        push_seq(3, 2, 1, 0, 1, 1, 1);
        check_all("after_abort");

        // Abort in IDLE blocks acceptance
        abort = 1'b1; cmd_valid = 1'b1; cmd_in_sel = 3'd1; cmd_load = CNT_W'(1);
        push_idle(1'b0);
        push_idle(1'b0);
        check_all("abort_blocks");
        abort = 1'b0; cmd_valid = 1'b0;
        push_idle(1'b1);
        check_all("abort_blocks_rel");

        // All-zero counts go straight to DONE
        send(0, 0, 0, 0, 0, 2, 0);
        push_seq(0, 0, 0, 0, 0, 2, 1);
        check_all("zero_counts");

        // cmd_valid held with changing fields while busy
        send(0, 1, 1, 1, 0, 0, 1);
        push_seq(0, 1, 1, 1, 0, 0, 1);
        push_seq(1, 3, 0, 0, 1, 1, 1);
        for (int i = 0; i < 12; i++) begin
            check_one("held_busy");
            cmd_in_sel  = 3'($urandom_range(0, 7));
            cmd_out_sel = 3'($urandom_range(0, 7));
            cmd_load    = CNT_W'($urandom_range(0, 3));
            cmd_mix     = CNT_W'($urandom_range(0, 3));
            cmd_unload  = CNT_W'($urandom_range(0, 3));
            cmd_div     = DIV_W'($urandom_range(0, 3));
        end
        check_one("held_done");
        cmd_in_sel = 3'd1; cmd_out_sel = 3'd3; cmd_load = '0; cmd_mix = '0;
        cmd_unload = CNT_W'(1); cmd_div = DIV_W'(1);
        check_one("held_idle");
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check_all("held_second");

        // Reset mid-sequence
        send(4, 1, 1, 1, 1, 0, 0);
        push_seq(4, 1, 1, 1, 1, 0, 1);
        check_n(4, "rst_pre");
        rst_n = 1'b0;
        exp_q.delete();
        push_idle(1'b1);
        check_one("rst_mid");
        rst_n = 1'b1;
        push_idle(1'b1);
        check_all("rst_release");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
